// File: rtl/mul8_seq_ctrl_pkg.sv
// mul8_seq_ctrl_pkg: shared widths and state encodings for the sequential multiplier
package mul8_seq_ctrl_pkg;
  localparam int OP_W = 8;
  localparam int PROD_W = 2 * OP_W;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [2:0] LAST_ITER = 3'd7;
endpackage

// File: rtl/mul8_seq_ctrl_if.sv
// mul8_seq_ctrl_if: start/busy/done handshake and operand/product bus
interface mul8_seq_ctrl_if;
  import mul8_seq_ctrl_pkg::*;
  logic start;
  logic [OP_W-1:0] a;
  logic [OP_W-1:0] b;
  logic busy;
  logic done;
  logic [PROD_W-1:0] product;
  modport master (output start, a, b, input busy, done, product);
  modport slave (input start, a, b, output busy, done, product);
endinterface

// File: rtl/mul8_seq_ctrl_add8.sv
// add8: 8-bit combinational ripple-carry adder; overflow is the unsigned carry-out
module add8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       c0,
  output logic [7:0] sum,
  output logic       overflow
);
  logic [8:0] c;
  assign c[0] = c0;
  for (genvar i = 0; i < 8; i++) begin : g_fa
    assign sum[i] = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign overflow = c[8];
endmodule

// File: rtl/mul8_seq_ctrl.sv
// mul8_seq_ctrl: 8x8 unsigned shift-and-add multiplier sequencing one add8 over 8 cycles
module mul8_seq_ctrl
  import mul8_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic clk,
  input logic reset,
  mul8_seq_ctrl_if.slave bus
);
  if (WIDTH != OP_W) begin : g_bad_width
    $error("mul8_seq_ctrl: WIDTH must be 8");
  end
  logic [1:0] state;
  logic [2:0] cnt;
  logic [OP_W-1:0] a_r;
  logic [PROD_W-1:0] p;
  logic [PROD_W-1:0] p_nxt;
  logic [PROD_W-1:0] product;
  logic [OP_W-1:0] sum;
  logic co;
  logic ready;
  assign ready = (state == S_IDLE) || (state == S_DONE);
  add8 u_add8 (
    .a        (p[15:8]),
    .b        (p[0] ? a_r : 8'h00),
    .c0       (1'b0),
    .sum      (sum),
    .overflow (co)
  );
  // keeping the carry as bit 15 means the upper half can never overflow
  assign p_nxt = {co, sum, p[7:1]};
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt <= '0;
      a_r <= '0;
      p <= '0;
      product <= '0;
    end else if (ready && bus.start) begin
      a_r <= bus.a;
      p <= {8'h00, bus.b};
      cnt <= '0;
      state <= S_RUN;
    end else if (state == S_RUN) begin
      p <= p_nxt;
      cnt <= cnt + 3'd1;
      if (cnt == LAST_ITER) begin
        state <= S_DONE;
        product <= p_nxt;
      end
    end else begin
      state <= S_IDLE;
    end
  end
  assign bus.busy = (state == S_RUN);
  assign bus.done = (state == S_DONE);
  assign bus.product = product;
endmodule

// File: tb/tb_mul8_seq_ctrl.sv
// tb_mul8_seq_ctrl: randomized self-checking bench against an a*b / fixed-latency reference
module tb_mul8_seq_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  mul8_seq_ctrl_if bus ();
  mul8_seq_ctrl #(.WIDTH(8)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  // Issues one multiply; lat is the edge count from accept to done (0 on timeout).
  task automatic run_mul(input logic [7:0] x, input logic [7:0] y, input bit noise,
                         output int lat, output logic [15:0] prod, output int busy_cnt);
    lat = 0;
    prod = 'x;
    busy_cnt = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = x;
    bus.b = y;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      bus.a = 8'($urandom);
      bus.b = 8'($urandom);
      bus.start = (noise && k >= 2 && k <= 6) ? 1'($urandom) : 1'b0;
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        lat = k - 1;
        prod = bus.product;
        break;
      end
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus.start = 1'b1;
    bus.a = 8'h05;
    bus.b = 8'h07;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags busy=%b done=%b want 0 0", bus.busy, bus.done);
    end
    checks++;
    if (bus.product !== 16'h0000) begin
      errors++;
      $display("FAIL reset_product got %h want 0000", bus.product);
    end
    reset = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_run busy=%b want 0", bus.busy);
    end
  endtask

  task automatic test_basic;
    int lat, bc;
    logic [15:0] prod;
    run_mul(8'd13, 8'd11, 1'b0, lat, prod, bc);
    checks++;
    if (lat !== 8) begin
      errors++;
      $display("FAIL basic_latency got %0d want 8", lat);
    end
    checks++;
    if (prod !== 16'h008F) begin
      errors++;
      $display("FAIL basic_product got %h want 008f", prod);
    end
    checks++;
    if (bc !== 8) begin
      errors++;
      $display("FAIL basic_busy_cycles got %0d want 8", bc);
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || bus.product !== 16'h008F) begin
      errors++;
      $display("FAIL basic_done_pulse done=%b product=%h want 0 008f", bus.done, bus.product);
    end
  endtask

  task automatic test_extremes;
    logic [7:0] xs [3] = '{8'hFF, 8'h80, 8'h00};
    logic [7:0] ys [3] = '{8'hFF, 8'h02, 8'hA5};
    int lat, bc;
    logic [15:0] prod;
    for (int i = 0; i < 3; i++) begin
      run_mul(xs[i], ys[i], 1'b0, lat, prod, bc);
      checks++;
      if (lat !== 8 || prod !== 16'(xs[i] * ys[i])) begin
        errors++;
        $display("FAIL extreme_%0d got lat=%0d prod=%h want lat=8 prod=%h",
                 i, lat, prod, 16'(xs[i] * ys[i]));
      end
    end
  endtask

  task automatic test_ignore_busy;
    int dones = 0;
    logic [15:0] prod = 'x;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = 8'd13;
    bus.b = 8'd11;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      bus.start = (k == 3);
      bus.a = (k == 3) ? 8'h02 : 8'd13;
      bus.b = (k == 3) ? 8'h03 : 8'd11;
      if (bus.done) begin
        dones++;
        prod = bus.product;
      end
    end
    checks++;
    if (dones !== 1) begin
      errors++;
      $display("FAIL ignore_busy_dones got %0d want 1", dones);
    end
    checks++;
    if (prod !== 16'h008F) begin
      errors++;
      $display("FAIL ignore_busy_product got %h want 008f", prod);
    end
  endtask

  task automatic test_back_to_back;
    int done_at [$];
    int bad_busy = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = 8'h07;
    bus.b = 8'h06;
    for (int k = 1; k <= 36; k++) begin
      @(negedge clk);
      if (bus.busy === bus.done) bad_busy++;
      if (bus.done) begin
        done_at.push_back(k);
        checks++;
        if (bus.product !== 16'h002A) begin
          errors++;
          $display("FAIL b2b_product at %0d got %h want 002a", k, bus.product);
        end
      end
    end
    bus.start = 1'b0;
    checks++;
    if (done_at.size() !== 4) begin
      errors++;
      $display("FAIL b2b_done_count got %0d want 4", done_at.size());
    end
    for (int i = 0; i < done_at.size(); i++) begin
      checks++;
      if (done_at[i] !== 9 * (i + 1)) begin
        errors++;
        $display("FAIL b2b_done_time idx %0d got %0d want %0d", i, done_at[i], 9 * (i + 1));
      end
    end
    checks++;
    if (bad_busy !== 0) begin
      errors++;
      $display("FAIL b2b_busy_shape got %0d bad cycles want 0", bad_busy);
    end
    repeat (12) @(negedge clk);
  endtask

  task automatic test_reset_mid_op;
    int dones = 0;
    int lat, bc;
    logic [15:0] prod;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = 8'hFF;
    bus.b = 8'hFF;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.product !== 16'h0000) begin
      errors++;
      $display("FAIL midreset_state busy=%b done=%b product=%h want 0 0 0000",
               bus.busy, bus.done, bus.product);
    end
    repeat (12) begin
      @(negedge clk);
      if (bus.done || bus.busy) dones++;
    end
    checks++;
    if (dones !== 0) begin
      errors++;
      $display("FAIL midreset_activity got %0d active cycles want 0", dones);
    end
    run_mul(8'h12, 8'h34, 1'b0, lat, prod, bc);
    checks++;
    if (lat !== 8 || prod !== 16'h03A8) begin
      errors++;
      $display("FAIL midreset_fresh got lat=%0d prod=%h want lat=8 prod=03a8", lat, prod);
    end
  endtask

  task automatic test_random;
    int lat, bc;
    logic [7:0] x, y;
    logic [15:0] prod;
    for (int i = 0; i < 2000; i++) begin
      x = 8'($urandom);
      y = 8'($urandom);
      run_mul(x, y, 1'b1, lat, prod, bc);
      checks++;
      if (lat !== 8 || prod !== 16'(x * y)) begin
        errors++;
        $display("FAIL random_%0d a=%h b=%h got lat=%0d prod=%h want lat=8 prod=%h",
                 i, x, y, lat, prod, 16'(x * y));
      end
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    test_reset();
    test_basic();
    test_extremes();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid_op();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
